request_arbiter_rr: RTL and testbench

//  Round-robin N:1 merge stage downstream of a bank of fifo_queue instances.

---
 rtl/request_arbiter_rr.sv | 101 ++++++++++
 tb/tb_request_arbiter_rr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_arbiter_rr.sv
// Round-robin N:1 merge of queue request handshakes into one registered output slot.
// The slot is reloaded in the same cycle it drains, so back-to-back requests cost no bubble.
module request_arbiter_rr #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUESTER              = 4,
    parameter int NUM_REQUESTER_LOG2         = 2
) (
    input  logic                                                clk_in,
    input  logic                                                reset_n_in,
    input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
    input  logic [NUM_REQUESTER-1:0]                            request_valid_packed_in,
    output logic [NUM_REQUESTER-1:0]                            issue_ack_packed_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               request_out,
    output logic                                                request_valid_out,
    output logic [NUM_REQUESTER_LOG2-1:0]                       grant_id_out,
    input  logic                                                issue_ack_in
);

    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int N = NUM_REQUESTER;
    localparam int L = NUM_REQUESTER_LOG2;

    logic [W-1:0] request_q, request_d;
    logic         valid_q, valid_d;
    logic [L-1:0] grant_q, grant_d;
    logic [N-1:0] ack_q, ack_d;
    logic [L-1:0] rr_ptr_q, rr_ptr_d;

    logic         drain;
    logic         slot_free;
    logic         any_eligible;
    logic [N-1:0] eligible;
    logic [L-1:0] winner;

    function automatic int wrap_add(input int base, input int offset);
        int sum;
        sum = base + offset;
        return (sum >= N) ? sum - N : sum;
    endfunction

    // Scanning from the farthest offset down leaves the nearest eligible index as winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eligible     = request_valid_packed_in & ~ack_q;
        any_eligible = 1'b0;
        winner       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[wrap_add(int'(rr_ptr_q), k)]) begin
                any_eligible = 1'b1;
                winner       = L'(wrap_add(int'(rr_ptr_q), k));
            end
        end
    end

    always_comb begin
        drain     = issue_ack_in & valid_q;
        slot_free = ~valid_q | drain;

        request_d = request_q;
        valid_d   = valid_q;
        grant_d   = grant_q;
        ack_d     = '0;
        rr_ptr_d  = rr_ptr_q;

        if (slot_free) begin
            if (any_eligible) begin
                request_d = request_packed_in[int'(winner)*W +: W];
                valid_d   = 1'b1;
                grant_d   = winner;
                ack_d     = N'(1) << winner;
                rr_ptr_d  = (winner == L'(N - 1)) ? '0 : winner + L'(1);
            end else begin
                request_d = '0;
                valid_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            request_q <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            ack_q     <= '0;
            rr_ptr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            request_q <= request_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign request_out          = request_q;
    assign request_valid_out    = valid_q;
    assign grant_id_out         = grant_q;
    assign issue_ack_packed_out = ack_q;

endmodule

// File: tb/tb_request_arbiter_rr.sv
// Randomized bench for request_arbiter_rr: upstream queues emulated with SV queues,
// expected outputs from a transaction-level round-robin model.
module tb_request_arbiter_rr;

    localparam int W = 64;
    localparam int N = 4;
    localparam int L = 2;

    logic           clk_in = 1'b0;
    logic           reset_n_in;
    logic [N*W-1:0] request_packed_in;
    logic [N-1:0]   request_valid_packed_in;
    logic [N-1:0]   issue_ack_packed_out;
    logic [W-1:0]   request_out;
    logic           request_valid_out;
    logic [L-1:0]   grant_id_out;
    logic           issue_ack_in;

    always #5 clk_in = ~clk_in;

    request_arbiter_rr #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .NUM_REQUESTER(N),
        .NUM_REQUESTER_LOG2(L)
    ) dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .request_packed_in(request_packed_in),
        .request_valid_packed_in(request_valid_packed_in),
        .issue_ack_packed_out(issue_ack_packed_out),
        .request_out(request_out),
        .request_valid_out(request_valid_out),
        .grant_id_out(grant_id_out),
        .issue_ack_in(issue_ack_in)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Upstream queue contents; the head is what the queue presents.
    logic [W-1:0] upq [N][$];
    logic [N-1:0] ack_pending;

    // Reference model state.
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    int           m_ptr;
    logic [N-1:0] m_ack;

    logic [N-1:0] prev_elig;
    int           wait_cnt [N];
    int           glog [$];

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
        m_ack   = '0;
        prev_elig = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            request_valid_packed_in[i]  = (upq[i].size() > 0);
            request_packed_in[i*W +: W] = (upq[i].size() > 0) ? upq[i][0] : '0;
        end
    endtask

    // Predicts the registered outputs after the coming edge from the inputs now driven.
    task automatic model_step();
        bit           drain;
        bit           free;
        int           w;
        logic [N-1:0] elig;
        drain = issue_ack_in && m_valid;
        free  = !m_valid || drain;
        elig  = request_valid_packed_in & ~m_ack;
        w     = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_ack = '0;
        if (free) begin
            if (w >= 0) begin
                m_valid  = 1'b1;
                m_data   = upq[w][0];
                m_id     = w;
                m_ack[w] = 1'b1;
                m_ptr    = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
                m_data  = '0;
            end
        end
    endtask

    task automatic check_outputs();
        check("valid", request_valid_out, m_valid);
        check("data", request_out, m_data);
        check("grant", grant_id_out, m_id);
        check("ack", issue_ack_packed_out, m_ack);
        check("onehot", $countones(issue_ack_packed_out) <= 1, 1);
    endtask

    // Bounded-wait check taken directly from the DUT's ack pulses.
    task automatic fairness();
        int j;
        int worst;
        j = -1;
        for (int i = 0; i < N; i++) if (issue_ack_packed_out[i]) j = i;
        if (j >= 0) glog.push_back(j);
        worst = 0;
        for (int i = 0; i < N; i++) begin
            if (!prev_elig[i] || i == j) wait_cnt[i] = 0;
            else if (j >= 0) wait_cnt[i]++;
            if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        if (j >= 0) check("fair_wait", worst <= N - 1, 1);
    endtask

    // mode: 0 random, 1 saturate, 2 saturate with downstream stall, 3 drain (no new data)
    task automatic step(input int mode);
        check_outputs();
        fairness();
        for (int i = 0; i < N; i++)
            if (ack_pending[i] && upq[i].size() > 0) void'(upq[i].pop_front());
        ack_pending = issue_ack_packed_out;
        for (int i = 0; i < N; i++) begin
            if (mode == 0 && upq[i].size() < 6 && $urandom_range(0, 2) == 0)
                upq[i].push_back(rand_word());
            if (mode == 1 || mode == 2)
                while (upq[i].size() < 3) upq[i].push_back(rand_word());
        end
        drive_inputs();
        issue_ack_in = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode != 2);
        prev_elig = request_valid_packed_in & ~issue_ack_packed_out;
        model_step();
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) begin
            @(negedge clk_in);
            step(mode);
        end
    endtask

    task automatic drain_all();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk_in);
            step(3);
            done = (upq[0].size() + upq[1].size() + upq[2].size() + upq[3].size() == 0)
                   && !m_valid && ack_pending == '0 && m_ack == '0;
        end
        check("drain_done", done, 1);
    endtask

    task automatic release_reset();
        @(negedge clk_in);
        reset_n_in   = 1'b1;
        issue_ack_in = 1'b1;
        model_reset();
        prev_elig = request_valid_packed_in;
        model_step();
    endtask

    initial begin
        reset_n_in = 1'b0;
        issue_ack_in = 1'b0;
        ack_pending = '0;
        request_packed_in = '0;
        request_valid_packed_in = '0;
        model_reset();

        // Reset with every requester valid.
        for (int i = 0; i < N; i++) repeat (3) upq[i].push_back(rand_word());
        drive_inputs();
        repeat (3) @(negedge clk_in);
        check_outputs();
        release_reset();
        glog.delete();
        @(negedge clk_in);
        check("rst_rel_ack", issue_ack_packed_out, 4'b0001);
        check("rst_rel_grant", grant_id_out, 0);
        step(1);

        // Saturated arbitration: strict 0,1,2,3 rotation with no bubble.
        run(11, 1);
        check("rot_len", glog.size() >= 8, 1);
        for (int k = 0; k < 8 && k < glog.size(); k++) check("rot_seq", glog[k], k % N);

        // Downstream stall then resume.
        run(5, 2);
        run(4, 1);

        // Single requester, stale valid must not cause a second grant.
        drain_all();
        @(negedge clk_in);
        upq[2].push_back(64'hA5);
        glog.delete();
        step(3);
        run(5, 3);
        check("single_cnt", glog.size(), 1);
        if (glog.size() > 0) check("single_id", glog[0], 2);

        // Wrap: pointer at 3 with requesters 1 and 3 pending.
        drain_all();
        @(negedge clk_in);
        upq[2].push_back(rand_word());
        step(3);
        @(negedge clk_in);
        repeat (2) begin
            upq[1].push_back(rand_word());
            upq[3].push_back(rand_word());
        end
        step(3);
        glog.delete();
        run(6, 3);
        check("wrap_len", glog.size() >= 3, 1);
        if (glog.size() >= 3) begin
            check("wrap_0", glog[0], 3);
            check("wrap_1", glog[1], 1);
            check("wrap_2", glog[2], 3);
        end

        // Randomized traffic and downstream backpressure.
        run(1500, 0);

        // Asynchronous reset mid-cycle while the slot is full.
        run(4, 1);
        @(posedge clk_in);
        #2;
        check("pre_rst_valid", request_valid_out, 1);
        reset_n_in = 1'b0;
        #1;
        check("arst_valid", request_valid_out, 0);
        check("arst_data", request_out, 0);
        check("arst_grant", grant_id_out, 0);
        check("arst_ack", issue_ack_packed_out, 0);
        for (int i = 0; i < N; i++)
            if (ack_pending[i] && upq[i].size() > 0) void'(upq[i].pop_front());
        ack_pending = '0;
        for (int i = 0; i < N; i++) while (upq[i].size() < 3) upq[i].push_back(rand_word());
        drive_inputs();
        release_reset();
        glog.delete();
        run(8, 1);
        check("arst_restart", glog.size() > 0 ? glog[0] : -1, 0);
        run(200, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
